// File: rtl/mult_div_unit_if.sv
// rtl/mult_div_unit_if.sv - start/done request and result bundle for mult_div_unit
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div0;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, div0, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, div0, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multicycle shift-add multiplier / restoring divider producing HI/LO
// Optional MULTDIV_EARLY_OUT_EN: multiplies finish once the remaining multiplier bits are zero.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic          clock,
    input  logic          reset,
    mult_div_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t           r_state, w_state_next;
    logic             r_is_div, r_neg_q, r_neg_r;
    logic [WIDTH:0]   r_acc;
    logic [WIDTH-1:0] r_lo, r_mcand;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_hi_out, r_lo_out;
    logic             r_done, r_div0;

    logic             w_signed, w_div_op, w_div0_req;
    logic [WIDTH-1:0] w_a_mag, w_b_mag;
    logic [WIDTH:0]   w_mul_sum, w_rem_sh, w_trial, w_iter_acc;
    logic [WIDTH-1:0] w_iter_lo;
    logic             w_div_ok;
    logic [CW-1:0]    w_count_next;
    logic [2*WIDTH-1:0] w_prod, w_prod_s;
    logic [WIDTH-1:0] w_quo, w_rem;

    assign w_signed   = ~bus.op[1];
    assign w_div_op   = bus.op[0];
    assign w_div0_req = bus.start && w_div_op && (bus.b == '0);
    assign w_a_mag    = (w_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign w_b_mag    = (w_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    // acc holds the upper product half (multiply) or the partial remainder (divide)
    assign w_mul_sum    = r_acc + (r_lo[0] ? {1'b0, r_mcand} : '0);
    assign w_rem_sh     = {r_acc[WIDTH-1:0], r_lo[WIDTH-1]};
    assign w_trial      = w_rem_sh - {1'b0, r_mcand};
    assign w_div_ok     = ~w_trial[WIDTH];
    assign w_count_next = r_count - CW'(1);

    always_comb begin
        w_iter_acc = {1'b0, w_mul_sum[WIDTH:1]};
        w_iter_lo  = {w_mul_sum[0], r_lo[WIDTH-1:1]};
        if (r_is_div) begin
            w_iter_acc = w_div_ok ? w_trial : w_rem_sh;
            w_iter_lo  = {r_lo[WIDTH-2:0], w_div_ok};
        end
    end

`ifdef MULTDIV_EARLY_OUT_EN
    // an early exit leaves the product short of r_count shifts; finish them here
    assign w_prod = {r_acc[WIDTH-1:0], r_lo} >> r_count;
`else
    assign w_prod = {r_acc[WIDTH-1:0], r_lo};
`endif
    assign w_prod_s = r_neg_q ? -w_prod : w_prod;
    assign w_quo    = r_neg_q ? -r_lo : r_lo;
    assign w_rem    = r_neg_r ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (bus.start && !w_div0_req) w_state_next = S_RUN;
            S_RUN: begin
                if (r_count == CW'(1)) w_state_next = S_FIX;
`ifdef MULTDIV_EARLY_OUT_EN
                else if (!r_is_div && ((w_iter_lo & ~({WIDTH{1'b1}} << w_count_next)) == '0))
                    w_state_next = S_FIX;
`endif
            end
            S_FIX:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_acc    <= '0;
            r_lo     <= '0;
            r_mcand  <= '0;
            r_count  <= '0;
            r_hi_out <= '0;
            r_lo_out <= '0;
            r_done   <= 1'b0;
            r_div0   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_div0 <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_div0_req) begin
                        r_done <= 1'b1;
                        r_div0 <= 1'b1;
                    end else if (bus.start) begin
                        r_is_div <= w_div_op;
                        r_neg_q  <= w_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        r_neg_r  <= w_signed && w_div_op && bus.a[WIDTH-1];
                        r_acc    <= '0;
                        r_lo     <= w_div_op ? w_a_mag : w_b_mag;
                        r_mcand  <= w_div_op ? w_b_mag : w_a_mag;
                        r_count  <= CW'(WIDTH);
                    end
                end
                S_RUN: begin
                    r_acc   <= w_iter_acc;
                    r_lo    <= w_iter_lo;
                    r_count <= w_count_next;
                end
                S_FIX: begin
                    r_hi_out <= r_is_div ? w_rem : w_prod_s[2*WIDTH-1:WIDTH];
                    r_lo_out <= r_is_div ? w_quo : w_prod_s[WIDTH-1:0];
                    r_done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (r_state != S_IDLE);
    assign bus.done = r_done;
    assign bus.div0 = r_div0;
    assign bus.hi   = r_hi_out;
    assign bus.lo   = r_lo_out;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - scoreboard bench for mult_div_unit
module tb_mult_div_unit;
    localparam int W = 32;

    typedef struct {
        string       tag;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        div0;
        int          done_at;
        int          busy;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   busy_cnt = 0;
    exp_t sb[$];
    logic [31:0] m_hi = '0, m_lo = '0;

    mult_div_unit_if #(.WIDTH(W)) bus();
    mult_div_unit #(.WIDTH(W)) dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // model of HI/LO written straight from the arithmetic definitions
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
        exp_t e;
        logic [63:0] p, q, r;
        logic [31:0] mag;
        int iters;
        e.tag = tag; e.div0 = 1'b0;
        iters = W;
        case (op)
            2'b00: begin p = longint'($signed(a)) * longint'($signed(b)); e.hi = p[63:32]; e.lo = p[31:0]; end
            2'b10: begin p = {32'b0, a} * {32'b0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
            2'b01: if (b != 0) begin
                q = longint'($signed(a)) / longint'($signed(b));
                r = longint'($signed(a)) % longint'($signed(b));
                e.lo = q[31:0]; e.hi = r[31:0];
            end
            default: if (b != 0) begin e.lo = a / b; e.hi = a % b; end
        endcase
`ifdef MULTDIV_EARLY_OUT_EN
        if (!op[0]) begin
            mag = (op == 2'b00 && b[31]) ? -b : b;
            iters = 1;
            for (int i = 0; i < W; i++) if (mag[i]) iters = i + 1;
        end
`endif
        if (op[0] && b == 0) begin
            e.hi = m_hi; e.lo = m_lo; e.div0 = 1'b1;
            e.done_at = cyc + 1; e.busy = 0;
        end else begin
            e.done_at = cyc + 1 + iters + 1; e.busy = iters + 1;
        end
        m_hi = e.hi; m_lo = e.lo;
        sb.push_back(e);
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        @(posedge clock); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin @(posedge clock); #1; n++; end
        if (sb.size() != 0) check_eq({tag, "_timeout"}, 64'(sb.size()), 64'd0);
    endtask

    always @(negedge clock) begin
        if (reset) busy_cnt = 0;
        else begin
            if (bus.busy) busy_cnt++;
            if (bus.div0 && !bus.done) check_eq("div0_without_done", 1, 0);
            if (bus.done) begin
                if (sb.size() == 0) check_eq("spurious_done", 1, 0);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    check_eq({e.tag, "_hi"}, 64'(bus.hi), 64'(e.hi));
                    check_eq({e.tag, "_lo"}, 64'(bus.lo), 64'(e.lo));
                    check_eq({e.tag, "_div0"}, 64'(bus.div0), 64'(e.div0));
                    check_eq({e.tag, "_done_cycle"}, 64'(cyc), 64'(e.done_at));
                    check_eq({e.tag, "_busy_cycles"}, 64'(busy_cnt), 64'(e.busy));
                end
                busy_cnt = 0;
            end
        end
    end

    initial begin
        int n;
        logic [1:0] rop;
        logic [31:0] ra, rb;
        bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
        repeat (3) @(posedge clock);
        #1;
        check_eq("rst_busy", 64'(bus.busy), 0);
        check_eq("rst_done", 64'(bus.done), 0);
        check_eq("rst_div0", 64'(bus.div0), 0);
        check_eq("rst_hilo", {bus.hi, bus.lo}, 0);
        reset = 1'b0;
        @(posedge clock); #1;

        issue(2'b00, 32'hFFFF_FFFD, 32'd7, "mult_neg3x7");           wait_idle("t1");
        issue(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");      wait_idle("t2");
        issue(2'b00, 32'd5, 32'd1, "mult_5x1");                       wait_idle("t3");
        issue(2'b01, 32'hFFFF_FFF9, 32'd2, "div_neg7_2");             wait_idle("t4");
        issue(2'b11, 32'd7, 32'd2, "divu_7_2");                       wait_idle("t5");
        issue(2'b01, 32'd1234, 32'd0, "div_by_zero");                 wait_idle("t6");
        issue(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1");     wait_idle("t7");
        issue(2'b01, 32'd7, 32'hFFFF_FFFE, "div_7_neg2");             wait_idle("t8");

        issue(2'b00, 32'd9, 32'hFFFF_FFFC, "ignored_start");
        repeat (3) @(posedge clock);
        #1;
        bus.start = 1'b1; bus.op = 2'b10; bus.a = 32'd100; bus.b = 32'd100;
        @(posedge clock); #1;
        bus.start = 1'b0;
        wait_idle("t9");

        issue(2'b10, 32'd123, 32'd456, "aborted");
        repeat (5) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        sb.delete(); m_hi = '0; m_lo = '0;
        check_eq("abort_busy", 64'(bus.busy), 0);
        check_eq("abort_done", 64'(bus.done), 0);
        check_eq("abort_hilo", {bus.hi, bus.lo}, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (40) @(posedge clock);
        #1;
        issue(2'b10, 32'd6, 32'd7, "multu_6x7");                      wait_idle("t10");

        issue(2'b11, 32'd1000, 32'd7, "b2b_first");
        n = 0;
        while (!bus.done && n < 100) begin @(posedge clock); #1; n++; end
        check_eq("b2b_done_seen", 64'(bus.done), 1);
        issue(2'b00, 32'hFFFF_0000, 32'h0001_2345, "b2b_second");     wait_idle("t11");

        for (int i = 0; i < 10; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i % 2 == 1) ? 32'($urandom_range(0, 15)) : $urandom;
            if (i == 4) begin rop = 2'b11; rb = '0; end
            issue(rop, ra, rb, $sformatf("rand%0d_op%0d", i, rop));
            wait_idle("trand");
        end

        repeat (5) @(posedge clock);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
